// File: rtl/player_datapath.sv
// Player sprite datapath: holds position, latches direction requests, steps once per
// frame on load_coord, and scans the SIZE x SIZE sprite for draw/erase.
module player_datapath #(
  parameter int unsigned X_MAX  = 160,
  parameter int unsigned Y_MAX  = 120,
  parameter int unsigned SIZE   = 5,
  parameter int unsigned STEP   = 1,
  parameter int unsigned INIT_X = 78,
  parameter int unsigned INIT_Y = 58,
  parameter logic [2:0]  COLOUR = 3'b110
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_coord,
  input  logic       move_en,
  input  logic [3:0] self_state,
  input  logic [3:0] dir,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       hit_edge
);

  localparam int unsigned X_LIM = X_MAX - SIZE;
  localparam int unsigned Y_LIM = Y_MAX - SIZE;
  localparam int unsigned CW    = (SIZE > 1) ? $clog2(SIZE) : 1;

  // dir / request bit positions
  localparam int unsigned UP    = 3;
  localparam int unsigned DOWN  = 2;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 0;

  logic [7:0]    px_q, px_d;
  logic [6:0]    py_q, py_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [3:0]    req_q, req_d;
  logic [3:0]    eff;
  logic          scanning;

  assign scanning = (self_state == 4'd1) || (self_state == 4'd2);
  assign eff      = req_q | dir;

  // Next-state: position step with clamping, request latching, sprite scan counter
  always_comb begin
    px_d  = px_q;
    py_d  = py_q;
    col_d = col_q;
    row_d = row_q;
    req_d = req_q;

    if (load_coord) begin
      if (eff[LEFT] && !eff[RIGHT])
        px_d = (px_q >= 8'(STEP)) ? px_q - 8'(STEP) : 8'd0;
      else if (eff[RIGHT] && !eff[LEFT])
        px_d = (px_q >= 8'(X_LIM - STEP)) ? 8'(X_LIM) : px_q + 8'(STEP);

      if (eff[UP] && !eff[DOWN])
        py_d = (py_q >= 7'(STEP)) ? py_q - 7'(STEP) : 7'd0;
      else if (eff[DOWN] && !eff[UP])
        py_d = (py_q >= 7'(Y_LIM - STEP)) ? 7'(Y_LIM) : py_q + 7'(STEP);

      req_d = 4'd0;
    end else if (move_en) begin
      req_d = req_q | dir;
    end

    if (!scanning) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == CW'(SIZE - 1)) begin
      col_d = '0;
      row_d = (row_q == CW'(SIZE - 1)) ? '0 : row_q + CW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q  <= 8'(INIT_X);
      py_q  <= 7'(INIT_Y);
      col_q <= '0;
      row_q <= '0;
      req_q <= 4'd0;
    end else begin
      px_q  <= px_d;
      py_q  <= py_d;
      col_q <= col_d;
      row_q <= row_d;
      req_q <= req_d;
    end
  end

  // Pixel outputs follow registered state so pixel (0,0) appears in the first scan cycle
  always_comb begin
    x_out      = px_q + 8'(col_q);
    y_out      = py_q + 7'(row_q);
    colour_out = (self_state == 4'd1) ? COLOUR : 3'b000;
    hit_edge   = (px_q == 8'd0) || (px_q == 8'(X_LIM)) ||
                 (py_q == 7'd0) || (py_q == 7'(Y_LIM));
  end

endmodule

// File: doc/player_datapath.md
Name: player_datapath

Overview:
- Datapath for the player ("self") sprite, directly downstream of the game control FSM.
- Holds the player position and captures direction-key requests. It steps the position once per frame on load_coord.
- During draw/erase it scans the SIZE x SIZE sprite one pixel per clock and emits VGA pixel coordinates and colour. It also flags when the sprite sits against the screen edge.

Parameters:
- X_MAX, 160, screen width in pixels
- Y_MAX, 120, screen height in pixels
- SIZE, 5, sprite edge length; one scan is SIZE*SIZE = 25 cycles, matching the FSM self counter of 0..24
- STEP, 1, pixels moved per frame per axis
- INIT_X, 78, reset x of the sprite top-left
- INIT_Y, 58, reset y of the sprite top-left
- COLOUR, 3'b110, draw colour

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load_coord  in  1  one-cycle pulse; apply pending move, clear requests
- move_en  in  1  high = capture direction keys into request latches
- self_state  in  4  0 idle, 1 draw, 2 erase, other values treated as idle
- dir  in  4  {up, down, left, right}, active-high, already synchronised
- x_out  out  8  pixel x = px + col
- y_out  out  7  pixel y = py + row
- colour_out  out  3  COLOUR when drawing, 3'b000 otherwise
- hit_edge  out  1  high when px==0, px==X_MAX-SIZE, py==0 or py==Y_MAX-SIZE

Behaviour:
- Single clock domain. Reset is asynchronous and active-low, with clk and reset_n as the port names. All registers clear immediately on reset_n=0.
- Reset values:
  - px=INIT_X, py=INIT_Y
  - col=0, row=0
  - request latches = 0
  - x_out=INIT_X, y_out=INIT_Y, colour_out=0
  - hit_edge=0 with the defaults
- Request latches: when move_en=1, each latch req[i] |= dir[i]. When move_en=0, the latches hold.
- Move on load_coord=1 (one clock):
  - Effective request e = req | dir. The same-cycle key counts.
  - Horizontal: if e.left and not e.right, px = max(px-STEP, 0). If e.right and not e.left, px = min(px+STEP, X_MAX-SIZE). Both or neither leaves px unchanged.
  - Vertical: the same rule with up/down on py, limit Y_MAX-SIZE.
  - All request latches clear in the same edge. A clear takes priority over capture when move_en is also high.
- Scan counter:
  - While self_state is 1 or 2, col increments each clock. At col==SIZE-1, col goes to 0 and row increments.
  - At row==SIZE-1 and col==SIZE-1, both wrap to 0, so the scan repeats every 25 cycles.
  - When self_state is any other value, col and row are forced to 0 on the next edge.
- Outputs x_out, y_out, colour_out are combinational from the registered px/py/col/row and from self_state. Pixel (0,0) is presented in the first cycle self_state is 1 or 2, aligned with the FSM plot.
  - Arithmetic: x_out = px + col at 8 bits; y_out = py + row at 7 bits. No overflow is possible within the clamp range.
- colour_out = COLOUR only when self_state==1; 3'b000 for erase and idle.
- hit_edge is combinational from px/py and updates the cycle after the load_coord edge that reaches a boundary.
- Position changes only on load_coord. A load_coord during a scan is a protocol error and is not guarded; the position updates anyway.
- self_state switching 1->2 without passing through idle continues the scan from the current col/row; the FSM always returns through idle.
- Reset mid-scan aborts the scan; outputs return to reset values asynchronously.

Test Plan:
- Reset: hold reset_n=0 -> px=78, py=58, x_out=78, y_out=58, colour_out=0, hit_edge=0; release; no activity -> values hold.
- Draw scan: self_state=1 for 25 cycles -> (x,y) sequence (78,58),(79,58)..(82,58),(78,59)..(82,62), colour=6. Cycle 26 -> back to (78,58). Set self_state=0 -> next cycle col=row=0.
- Erase scan: self_state=2 for 25 cycles -> same coordinates, colour_out=0 throughout.
- Latched move: move_en=1, pulse dir=right for 1 cycle, drop move_en, then load_coord -> px=79, py=58. A second load_coord without keys -> no change (latch cleared).
- Conflict and combine: dir=left+right+down held during load_coord with empty latches -> px unchanged, py=59.
- Clamp and edge: drive right for 80 frames -> px saturates at 155 and hit_edge=1. Then one left frame -> px=154, hit_edge=0. Also check py reaching 0 via up -> hit_edge=1.
- Async reset mid-scan: assert reset_n at scan cycle 12 between clock edges -> outputs immediately (78,58,0); scan restarts at pixel 0 after release.
